// File: rtl/alu_pkg.sv
// Shared ALU definitions: divider sequencer state encoding and constants.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package alu_pkg;

  // Default ALU datapath width.
  localparam int ALU_WIDTH = 32;

  // Divider sequencer states (2-bit encoding).
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_DONE   = 2'd2
  } div_state_t;

  // LO value reported for a divide-by-zero (all ones).
  localparam logic [ALU_WIDTH-1:0] DIV_ZERO_LO = '1;

endpackage

// File: rtl/divide32.sv
// Combinational signed divider: result = {remainder, quotient}.
// Latency: combinational; needs a multicycle settle window from its caller.
// Backpressure: none (pure function of its inputs).
//
// Ports:
//   dividend, divisor : signed operands
//   result            : [2W-1:W] remainder, [W-1:0] quotient
// A zero divisor yields all zeros; callers are expected to bypass that case.
module divide32 #(
  parameter int WIDTH = 32
) (
  input  logic signed [WIDTH-1:0]   dividend,
  input  logic signed [WIDTH-1:0]   divisor,
  output logic        [2*WIDTH-1:0] result
);

  logic signed [WIDTH-1:0] quo;
  logic signed [WIDTH-1:0] rem;

  always_comb begin
    quo = '0;
    rem = '0;
    if (divisor == '1) begin
      // Divide by -1 is a negate; this also gives the wrapped result for
      // the most-negative dividend without relying on overflowing division.
      quo = '0 - dividend;
      rem = '0;
    end else if (divisor != '0) begin
      quo = dividend / divisor;
      rem = dividend % divisor;
    end
  end

  assign result = {rem, quo};

endmodule

// File: rtl/div_seq_ctrl.sv
// Sequencer upstream of the combinational divider: latch operands, wait, capture HI/LO.
// Latency: result valid SETTLE_CYCLES edges after the accept edge; 0 extra for divide-by-zero.
// Backpressure: start_ready only in IDLE; result held in DONE until res_ready.
//
// Ports:
//   clock, clear               : rising-edge clock, synchronous active-high reset
//   start_valid / start_ready  : request handshake, operands on dividend_in / divisor_in
//   div_dividend, div_divisor  : registered operands driven to the divider
//   div_result                 : divider output {remainder, quotient}
//   res_valid / res_ready      : result handshake, data on hi_out / lo_out / div_by_zero
//   busy                       : request in flight (SETTLE or DONE)
module div_seq_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH         = ALU_WIDTH,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic               clock,
  input  logic               clear,
  input  logic               start_valid,
  output logic               start_ready,
  input  logic [WIDTH-1:0]   dividend_in,
  input  logic [WIDTH-1:0]   divisor_in,
  output logic [WIDTH-1:0]   div_dividend,
  output logic [WIDTH-1:0]   div_divisor,
  input  logic [2*WIDTH-1:0] div_result,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [WIDTH-1:0]   hi_out,
  output logic [WIDTH-1:0]   lo_out,
  output logic               div_by_zero,
  output logic               busy
);

  if ((SETTLE_CYCLES < 1) || (SETTLE_CYCLES > 15)) begin : g_bad_settle
    $error("div_seq_ctrl: SETTLE_CYCLES must be in 1..15");
  end

  // Counter is loaded with SETTLE_CYCLES-1 so that capture happens on the
  // edge that closes the last full settle cycle.
  localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);

  div_state_t state;
  logic [3:0] cnt;

  // Handshake/status flags come from the state register alone, so there is
  // no combinational path from start_valid or res_ready to any output.
  assign start_ready = (state == S_IDLE);
  assign res_valid   = (state == S_DONE);
  assign busy        = (state == S_SETTLE) || (state == S_DONE);

  always_ff @(posedge clock) begin
    if (clear) begin
      state        <= S_IDLE;
      cnt          <= '0;
      div_dividend <= '0;
      div_divisor  <= '0;
      hi_out       <= '0;
      lo_out       <= '0;
      div_by_zero  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_valid) begin
            div_dividend <= dividend_in;
            div_divisor  <= divisor_in;
            if (divisor_in == '0) begin
              // Bypass the divider entirely; report dividend in HI.
              // DIV_ZERO_LO is all ones, so replicating one bit fits any WIDTH.
              hi_out      <= dividend_in;
              lo_out      <= {WIDTH{DIV_ZERO_LO[0]}};
              div_by_zero <= 1'b1;
              state       <= S_DONE;
            end else begin
              div_by_zero <= 1'b0;
              cnt         <= CNT_INIT;
              state       <= S_SETTLE;
            end
          end
        end
        S_SETTLE: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            hi_out <= div_result[2*WIDTH-1:WIDTH];
            lo_out <= div_result[WIDTH-1:0];
            state  <= S_DONE;
          end
        end
        S_DONE: begin
          if (res_ready) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Bench for div_seq_ctrl with the real divider, at SETTLE_CYCLES = 4, 1 and 15.
// Latency: n/a.
// Backpressure: driven randomly and in directed hold patterns.
module tb_div_seq_ctrl;
  import alu_pkg::*;

  localparam int N = 3;

  logic              clock;
  logic              clear;
  logic [N-1:0]      start_valid;
  logic [N-1:0]      start_ready;
  logic [31:0]       dividend_in  [N];
  logic [31:0]       divisor_in   [N];
  logic [31:0]       div_dividend [N];
  logic [31:0]       div_divisor  [N];
  logic [63:0]       div_result   [N];
  logic [N-1:0]      res_valid;
  logic [N-1:0]      res_ready;
  logic [31:0]       hi_out       [N];
  logic [31:0]       lo_out       [N];
  logic [N-1:0]      div_by_zero;
  logic [N-1:0]      busy;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  for (genvar g = 0; g < N; g++) begin : g_inst
    localparam int SC = (g == 0) ? 4 : ((g == 1) ? 1 : 15);
    div_seq_ctrl #(.WIDTH(32), .SETTLE_CYCLES(SC)) u_dut (
      .clock        (clock),
      .clear        (clear),
      .start_valid  (start_valid[g]),
      .start_ready  (start_ready[g]),
      .dividend_in  (dividend_in[g]),
      .divisor_in   (divisor_in[g]),
      .div_dividend (div_dividend[g]),
      .div_divisor  (div_divisor[g]),
      .div_result   (div_result[g]),
      .res_valid    (res_valid[g]),
      .res_ready    (res_ready[g]),
      .hi_out       (hi_out[g]),
      .lo_out       (lo_out[g]),
      .div_by_zero  (div_by_zero[g]),
      .busy         (busy[g])
    );
    divide32 #(.WIDTH(32)) u_div (
      .dividend (div_dividend[g]),
      .divisor  (div_divisor[g]),
      .result   (div_result[g])
    );
  end

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic int sc_of(input int i);
    return (i == 0) ? 4 : ((i == 1) ? 1 : 15);
  endfunction

  // Reference signed division, truncating toward zero, done in 64 bits.
  function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r);
    longint la, lb, lq, lr;
    la = longint'($signed(a));
    lb = longint'($signed(b));
    lq = la / lb;
    lr = la % lb;
    q  = lq[31:0];
    r  = lr[31:0];
  endfunction

  task automatic check(input string nm, input int idx, input logic [63:0] act,
                       input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s[%0d]: got %h, expected %h", nm, idx, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // m_job: a request is outstanding; m_wait: edges left before the result shows.
  bit          m_job  [N];
  int          m_wait [N];
  logic [31:0] m_dd [N], m_dv [N], m_hi [N], m_lo [N], p_hi [N], p_lo [N];
  bit          m_dbz [N];

  always @(posedge clock) begin
    for (int i = 0; i < N; i++) begin
      if (clear) begin
        m_job[i] = 1'b0; m_wait[i] = 0;
        m_dd[i] = '0; m_dv[i] = '0; m_hi[i] = '0; m_lo[i] = '0; m_dbz[i] = 1'b0;
      end else if (!m_job[i]) begin
        if (start_valid[i]) begin
          m_job[i] = 1'b1;
          m_dd[i]  = dividend_in[i];
          m_dv[i]  = divisor_in[i];
          if (divisor_in[i] == 32'd0) begin
            m_wait[i] = 0;
            m_hi[i]   = dividend_in[i];
            m_lo[i]   = 32'hFFFF_FFFF;
            m_dbz[i]  = 1'b1;
          end else begin
            m_wait[i] = sc_of(i);
            m_dbz[i]  = 1'b0;
            ref_div(dividend_in[i], divisor_in[i], p_lo[i], p_hi[i]);
          end
        end
      end else if (m_wait[i] > 0) begin
        m_wait[i]--;
        if (m_wait[i] == 0) begin
          m_hi[i] = p_hi[i];
          m_lo[i] = p_lo[i];
        end
      end else if (res_ready[i]) begin
        m_job[i] = 1'b0;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clock) begin
    if (chk_en) begin
      for (int i = 0; i < N; i++) begin
        check("start_ready", i, 64'(start_ready[i]), 64'(!m_job[i]));
        check("busy",        i, 64'(busy[i]),        64'(m_job[i]));
        check("res_valid",   i, 64'(res_valid[i]),   64'(m_job[i] && m_wait[i] == 0));
        check("hi_out",      i, 64'(hi_out[i]),      64'(m_hi[i]));
        check("lo_out",      i, 64'(lo_out[i]),      64'(m_lo[i]));
        check("div_by_zero", i, 64'(div_by_zero[i]), 64'(m_dbz[i]));
        check("div_dividend",i, 64'(div_dividend[i]),64'(m_dd[i]));
        check("div_divisor", i, 64'(div_divisor[i]), 64'(m_dv[i]));
      end
    end
  end

  // ---------------- stimulus ----------------
  // One request on instance i. lat counts edges including the accept edge.
  task automatic do_req(input int i, input logic [31:0] a, input logic [31:0] b,
                        input int hold, input bit noise, output int lat);
    @(posedge clock); #1;
    start_valid[i] = 1'b1; dividend_in[i] = a; divisor_in[i] = b; res_ready[i] = 1'b0;
    @(posedge clock); #1;
    start_valid[i] = 1'b0;
    lat = 1;
    while (!res_valid[i] && lat < 40) begin
      if (noise) begin
        start_valid[i] = 1'($urandom_range(0, 1));
        dividend_in[i] = $urandom; divisor_in[i] = $urandom;
      end
      @(posedge clock); #1;
      lat++;
    end
    check("result_arrived", i, 64'(res_valid[i]), 64'd1);
    repeat (hold) begin
      if (noise) begin
        start_valid[i] = 1'($urandom_range(0, 1));
        dividend_in[i] = $urandom; divisor_in[i] = $urandom;
      end
      @(posedge clock); #1;
    end
    start_valid[i] = 1'b0;
    res_ready[i]   = 1'b1;
    @(posedge clock); #1;
    res_ready[i]   = 1'b0;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int lat;
    clear       = 1'b1;
    start_valid = '0;
    res_ready   = '0;
    for (int i = 0; i < N; i++) begin
      dividend_in[i] = '0; divisor_in[i] = '0;
    end
    repeat (3) @(posedge clock);
    #1;
    chk_en = 1'b1;
    check("rst_start_ready", 0, 64'(start_ready), 64'(3'b111));
    check("rst_busy",        0, 64'(busy),        64'd0);
    check("rst_res_valid",   0, 64'(res_valid),   64'd0);
    check("rst_hi",          0, 64'(hi_out[0]),   64'd0);
    check("rst_lo",          0, 64'(lo_out[0]),   64'd0);
    clear = 1'b0;

    // Basic divide.
    do_req(0, 32'd100, 32'd7, 0, 1'b0, lat);
    check("t1_lat", 0, 64'(lat), 64'd5);
    check("t1_lo",  0, 64'(lo_out[0]), 64'd14);
    check("t1_hi",  0, 64'(hi_out[0]), 64'd2);
    check("t1_dbz", 0, 64'(div_by_zero[0]), 64'd0);

    // Divide by zero bypass.
    do_req(0, 32'h0000_1234, 32'd0, 0, 1'b0, lat);
    check("t2_lat", 0, 64'(lat), 64'd1);
    check("t2_hi",  0, 64'(hi_out[0]), 64'h1234);
    check("t2_lo",  0, 64'(lo_out[0]), 64'hFFFF_FFFF);
    check("t2_dbz", 0, 64'(div_by_zero[0]), 64'd1);
    check("t2_idle",0, 64'(start_ready[0]), 64'd1);

    // Backpressure with ignored start pulses.
    do_req(0, 32'd1000, 32'd10, 6, 1'b1, lat);
    check("t3_lat",  0, 64'(lat), 64'd5);
    check("t3_idle", 0, 64'(start_ready[0]), 64'd1);
    check("t3_rv",   0, 64'(res_valid[0]), 64'd0);
    check("t3_lo",   0, 64'(lo_out[0]), 64'd100);
    check("t3_hi",   0, 64'(hi_out[0]), 64'd0);
    @(posedge clock); #1;
    check("t3_nosecond", 0, 64'(busy[0]), 64'd0);

    // Operand stability while inputs churn during settle.
    do_req(0, 32'd65536, 32'd256, 0, 1'b1, lat);
    check("t4_dd", 0, 64'(div_dividend[0]), 64'd65536);
    check("t4_dv", 0, 64'(div_divisor[0]),  64'd256);
    check("t4_lo", 0, 64'(lo_out[0]), 64'd256);
    check("t4_hi", 0, 64'(hi_out[0]), 64'd0);

    // Reset in the second settle cycle.
    @(posedge clock); #1;
    start_valid[0] = 1'b1; dividend_in[0] = 32'd50; divisor_in[0] = 32'd3;
    @(posedge clock); #1;
    start_valid[0] = 1'b0;
    @(posedge clock); #1;
    clear = 1'b1;
    @(posedge clock); #1;
    clear = 1'b0;
    check("t5_ready", 0, 64'(start_ready[0]), 64'd1);
    check("t5_busy",  0, 64'(busy[0]), 64'd0);
    check("t5_rv",    0, 64'(res_valid[0]), 64'd0);
    check("t5_hi",    0, 64'(hi_out[0]), 64'd0);
    check("t5_lo",    0, 64'(lo_out[0]), 64'd0);
    check("t5_dd",    0, 64'(div_dividend[0]), 64'd0);
    check("t5_dv",    0, 64'(div_divisor[0]), 64'd0);
    do_req(0, 32'd9, 32'd4, 0, 1'b0, lat);
    check("t5_lat", 0, 64'(lat), 64'd5);
    check("t5_lo2", 0, 64'(lo_out[0]), 64'd2);
    check("t5_hi2", 0, 64'(hi_out[0]), 64'd1);

    // Overflow case passes through: -2^31 / -1 wraps to -2^31, remainder 0.
    do_req(0, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0, lat);
    check("ovf_lo", 0, 64'(lo_out[0]), 64'h8000_0000);
    check("ovf_hi", 0, 64'(hi_out[0]), 64'd0);

    // Settle window extremes.
    do_req(1, 32'h7FFF_FFFF, 32'd3, 0, 1'b0, lat);
    check("t6a_lat", 1, 64'(lat), 64'd2);
    check("t6a_lo",  1, 64'(lo_out[1]), 64'h2AAA_AAAA);
    check("t6a_hi",  1, 64'(hi_out[1]), 64'd1);
    do_req(2, 32'h7FFF_FFFF, 32'd3, 0, 1'b0, lat);
    check("t6b_lat", 2, 64'(lat), 64'd16);
    check("t6b_lo",  2, 64'(lo_out[2]), 64'h2AAA_AAAA);
    check("t6b_hi",  2, 64'(hi_out[2]), 64'd1);

    // Random traffic on all three instances, checked every cycle by the model.
    repeat (3000) begin
      @(posedge clock); #1;
      clear = ($urandom_range(0, 199) == 0);
      for (int i = 0; i < N; i++) begin
        start_valid[i] = 1'($urandom_range(0, 1));
        dividend_in[i] = pick();
        divisor_in[i]  = pick();
        res_ready[i]   = ($urandom_range(0, 2) != 0);
      end
    end
    @(posedge clock); #1;
    clear = 1'b0; start_valid = '0; res_ready = '0;
    repeat (3) @(posedge clock);
    #1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
